// File: rtl/mem_boot_loader.sv
// Boot loader that streams command/data words into (or verifies against) NUM_MEMS
// single-port memories with active-low CEN/WEN/OEN, holding the core off via loading_o.
module mem_boot_loader #(
    parameter int ADDRESS_WIDTH = 11,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_MEMS      = 2,
    parameter int SEL_WIDTH     = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           cmd_valid_i,
    output logic                           cmd_ready_o,
    input  logic                           cmd_mode_i,
    input  logic [SEL_WIDTH-1:0]           cmd_sel_i,
    input  logic [ADDRESS_WIDTH-1:0]       cmd_base_i,
    input  logic [ADDRESS_WIDTH:0]         cmd_count_i,
    input  logic                           data_valid_i,
    output logic                           data_ready_o,
    input  logic [DATA_WIDTH-1:0]          data_i,
    output logic [NUM_MEMS-1:0]            mem_cen_n_o,
    output logic [NUM_MEMS-1:0]            mem_wen_n_o,
    output logic [NUM_MEMS-1:0]            mem_oen_n_o,
    output logic [ADDRESS_WIDTH-1:0]       mem_addr_o,
    output logic [DATA_WIDTH-1:0]          mem_din_o,
    input  logic [NUM_MEMS*DATA_WIDTH-1:0] mem_dout_i,
    output logic                           loading_o,
    output logic                           done_o,
    output logic                           cmd_error_o,
    output logic [CNT_WIDTH-1:0]           mismatch_count_o,
    output logic [ADDRESS_WIDTH-1:0]       first_mismatch_addr_o
);

    // state | meaning
    // IDLE  | waiting for a command
    // XFER  | accepting stream beats, one memory access per beat
    // DRAIN | last access settling (1 cycle write, 2 cycles verify)
    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic                     mode_q, mode_d;
    logic [SEL_WIDTH-1:0]     sel_q, sel_d;
    logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDRESS_WIDTH:0]   rem_q, rem_d;
    logic                     drain_q, drain_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    din_q, din_d;
    logic [NUM_MEMS-1:0]      cen_q, cen_d, wen_q, wen_d, oen_q, oen_d;
    logic                     done_q, done_d, err_q, err_d;
    logic [CNT_WIDTH-1:0]     mcnt_q, mcnt_d;
    logic [ADDRESS_WIDTH-1:0] maddr_q, maddr_d;
    logic                     v0_q, v0_d, v1_q, v1_d;
    logic [DATA_WIDTH-1:0]    exp0_q, exp0_d, exp1_q, exp1_d;
    logic [ADDRESS_WIDTH-1:0] a0_q, a0_d, a1_q, a1_d;

    logic [NUM_MEMS-1:0]      sel_oh;
    logic [DATA_WIDTH-1:0]    rd_word;
    logic                     beat;

    assign cmd_ready_o  = (state_q == IDLE) && !rst_i;
    assign data_ready_o = (state_q == XFER) && (rem_q != '0);
    assign beat         = data_valid_i && data_ready_o;

    always_comb begin
        sel_oh  = '0;
        rd_word = '0;
        for (int i = 0; i < NUM_MEMS; i++) begin
            sel_oh[i] = (sel_q == SEL_WIDTH'(i));
            if (sel_q == SEL_WIDTH'(i)) rd_word = mem_dout_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        drain_d = drain_q;
        addr_d  = addr_q;
        din_d   = din_q;
        cen_d   = '1;
        wen_d   = '1;
        oen_d   = '1;
        done_d  = 1'b0;
        err_d   = 1'b0;
        mcnt_d  = mcnt_q;
        maddr_d = maddr_q;
        v0_d    = 1'b0;
        exp0_d  = exp0_q;
        a0_d    = a0_q;
        v1_d    = v0_q;
        exp1_d  = exp0_q;
        a1_d    = a0_q;

        // Read issued two edges ago: memory output is now valid for comparison.
        if (v1_q && (rd_word != exp1_q)) begin
            if (mcnt_q == '0) maddr_d = a1_q;
            if (mcnt_q != '1) mcnt_d = mcnt_q + CNT_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    mode_d  = cmd_mode_i;
                    sel_d   = cmd_sel_i;
                    ptr_d   = cmd_base_i;
                    rem_d   = cmd_count_i;
                    drain_d = cmd_mode_i;
                    mcnt_d  = '0;
                    maddr_d = '0;
                    if (32'(cmd_sel_i) >= NUM_MEMS) err_d = 1'b1;
                    else if (cmd_count_i == '0)     done_d = 1'b1;
                    else                            state_d = XFER;
                end
            end
            XFER: begin
                if (beat) begin
                    addr_d = ptr_q;
                    ptr_d  = ptr_q + ADDRESS_WIDTH'(1);
                    rem_d  = rem_q - (ADDRESS_WIDTH+1)'(1);
                    cen_d  = ~sel_oh;
                    if (!mode_q) begin
                        wen_d = ~sel_oh;
                        din_d = data_i;
                    end else begin
                        oen_d = ~sel_oh;
                    end
                    v0_d   = mode_q;
                    exp0_d = data_i;
                    a0_d   = ptr_q;
                end else if (rem_q == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!drain_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            sel_q   <= '0;
            ptr_q   <= '0;
            rem_q   <= '0;
            drain_q <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            cen_q   <= '1;
            wen_q   <= '1;
            oen_q   <= '1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mcnt_q  <= '0;
            maddr_q <= '0;
            v0_q    <= 1'b0;
            exp0_q  <= '0;
            a0_q    <= '0;
            v1_q    <= 1'b0;
            exp1_q  <= '0;
            a1_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            drain_q <= drain_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            cen_q   <= cen_d;
            wen_q   <= wen_d;
            oen_q   <= oen_d;
            done_q  <= done_d;
            err_q   <= err_d;
            mcnt_q  <= mcnt_d;
            maddr_q <= maddr_d;
            v0_q    <= v0_d;
            exp0_q  <= exp0_d;
            a0_q    <= a0_d;
            v1_q    <= v1_d;
            exp1_q  <= exp1_d;
            a1_q    <= a1_d;
        end
    end

    assign mem_cen_n_o           = cen_q;
    assign mem_wen_n_o           = wen_q;
    assign mem_oen_n_o           = oen_q;
    assign mem_addr_o            = addr_q;
    assign mem_din_o             = din_q;
    assign loading_o             = (state_q != IDLE);
    assign done_o                = done_q;
    assign cmd_error_o           = err_q;
    assign mismatch_count_o      = mcnt_q;
    assign first_mismatch_addr_o = maddr_q;

endmodule

// File: tb/tb_mem_boot_loader.sv
// Bench for mem_boot_loader: two synchronous RAM models and an access scoreboard.
module tb_mem_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_mode;
    logic [1:0]  cmd_sel;
    logic [10:0] cmd_base;
    logic [11:0] cmd_count;
    logic        data_valid, data_ready;
    logic [31:0] data;
    logic [1:0]  mem_cen_n, mem_wen_n, mem_oen_n;
    logic [10:0] mem_addr;
    logic [31:0] mem_din;
    logic [63:0] mem_dout;
    logic        loading, done, cmd_error;
    logic [15:0] mismatch_count;
    logic [10:0] first_mismatch_addr;

    typedef struct {
        logic [1:0]  sel;
        logic [10:0] addr;
        logic        wr;
        logic [31:0] data;
    } acc_t;

    acc_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   load_cycles = 0;
    int   done_pulses = 0;
    int   err_pulses = 0;

    logic [31:0] ram [2][2048];
    logic [31:0] dout [2];
    assign mem_dout = {dout[1], dout[0]};

    always #5 clk = ~clk;

    mem_boot_loader dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_mode_i(cmd_mode),
        .cmd_sel_i(cmd_sel), .cmd_base_i(cmd_base), .cmd_count_i(cmd_count),
        .data_valid_i(data_valid), .data_ready_o(data_ready), .data_i(data),
        .mem_cen_n_o(mem_cen_n), .mem_wen_n_o(mem_wen_n), .mem_oen_n_o(mem_oen_n),
        .mem_addr_o(mem_addr), .mem_din_o(mem_din), .mem_dout_i(mem_dout),
        .loading_o(loading), .done_o(done), .cmd_error_o(cmd_error),
        .mismatch_count_o(mismatch_count), .first_mismatch_addr_o(first_mismatch_addr)
    );

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!mem_cen_n[m]) begin
                if (!mem_wen_n[m])      ram[m][mem_addr] <= mem_din;
                else if (!mem_oen_n[m]) dout[m] <= ram[m][mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (loading)   load_cycles++;
            if (done)      done_pulses++;
            if (cmd_error) err_pulses++;
            if ((mem_cen_n & mem_wen_n & mem_oen_n) != 2'b11) begin
                if (exp_q.size() == 0) begin
                    check("spurious_access", {mem_cen_n, mem_wen_n, mem_oen_n}, 6'h3f);
                end else begin
                    acc_t e;
                    logic [1:0] en;
                    e  = exp_q.pop_front();
                    en = (e.sel == 2'd0) ? 2'b10 : 2'b01;
                    check("access_ctl", {mem_cen_n, mem_wen_n, mem_oen_n, mem_addr},
                          {en, (e.wr ? en : 2'b11), (e.wr ? 2'b11 : en), e.addr});
                    if (e.wr) check("access_din", mem_din, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic mode, input logic [1:0] sel, input logic [10:0] base,
                         input logic [11:0] count);
        int t = 0;
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_sel   = sel;
        cmd_base  = base;
        cmd_count = count;
        while (!cmd_ready && t < 50) begin
            tick();
            t++;
        end
        check("cmd_accept", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic stream(input logic mode, input logic [1:0] sel, input logic [10:0] base,
                          input int n, input logic [31:0] w[$], input bit stall, input bit chk_end);
        for (int k = 0; k < n; k++) begin
            acc_t e;
            int t = 0;
            data_valid = 1'b1;
            data       = w[k];
            while (!data_ready && t < 50) begin
                tick();
                t++;
            end
            check("beat_ready", data_ready, 1);
            e.sel  = sel;
            e.addr = base + 11'(k);
            e.wr   = !mode;
            e.data = w[k];
            exp_q.push_back(e);
            tick();
            data_valid = 1'b0;
            if (stall && k < n - 1) begin
                tick();
                check("stall_en_high", {mem_cen_n, mem_wen_n, mem_oen_n}, 6'h3f);
            end
        end
        if (chk_end) check("ready_after_last", data_ready, 0);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            cyc++;
            if (done) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_sel = '0; cmd_base = '0; cmd_count = '0;
        data_valid = 1'b0; data = '0;
        tick(); tick(); tick();
        check("rst_ready", {cmd_ready, data_ready, loading, done, cmd_error}, 5'b0);
        check("rst_en", {mem_cen_n, mem_wen_n, mem_oen_n}, 6'h3f);
        check("rst_data", {mem_addr, mem_din, mismatch_count, first_mismatch_addr}, '0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", cmd_ready, 1);

        // write mem 0, back-to-back
        load_cycles = 0; done_pulses = 0;
        issue(1'b0, 2'd0, 11'h010, 12'd4);
        stream(1'b0, 2'd0, 11'h010, 4, '{32'hA0, 32'hA1, 32'hA2, 32'hA3}, 1'b0, 1'b1);
        wait_done(c);
        check("t1_done_latency", c, 3);
        tick(); tick();
        check("t1_loading_cycles", load_cycles, 6);
        check("t1_done_pulses", done_pulses, 1);
        check("t1_queue_empty", exp_q.size(), 0);

        // write mem 1 with address wrap and stalls
        issue(1'b0, 2'd1, 11'h7FE, 12'd3);
        stream(1'b0, 2'd1, 11'h7FE, 3, '{32'h11, 32'h22, 32'h33}, 1'b1, 1'b1);
        wait_done(c);
        check("t2_done_latency", c, 3);
        check("t2_queue_empty", exp_q.size(), 0);
        check("t2_wrap_stored", ram[1][0], 32'h33);

        // verify mem 0 with two deliberate mismatches
        load_cycles = 0; done_pulses = 0;
        issue(1'b1, 2'd0, 11'h010, 12'd4);
        stream(1'b1, 2'd0, 11'h010, 4, '{32'hA0, 32'hFF, 32'hA2, 32'h00}, 1'b0, 1'b1);
        wait_done(c);
        check("t3_done_latency", c, 4);
        check("t3_mismatch_count", mismatch_count, 2);
        check("t3_first_mismatch", first_mismatch_addr, 11'h011);
        tick();
        check("t3_loading_cycles", load_cycles, 7);
        check("t3_queue_empty", exp_q.size(), 0);

        // bad select
        load_cycles = 0; err_pulses = 0; done_pulses = 0;
        issue(1'b0, 2'd3, 11'h010, 12'd4);
        tick(); tick(); tick();
        check("t4_err_pulses", err_pulses, 1);
        check("t4_no_done", done_pulses, 0);
        check("t4_no_loading", load_cycles, 0);
        check("t4_mm_cleared", mismatch_count, 0);
        check("t4_ready", cmd_ready, 1);

        // zero count
        load_cycles = 0; err_pulses = 0; done_pulses = 0;
        issue(1'b0, 2'd0, 11'h010, 12'd0);
        tick(); tick(); tick();
        check("t5_done_pulses", done_pulses, 1);
        check("t5_no_loading", load_cycles, 0);
        check("t5_no_err", err_pulses, 0);

        // reset during the third beat of an 8-beat write
        issue(1'b0, 2'd0, 11'h100, 12'd8);
        stream(1'b0, 2'd0, 11'h100, 2, '{32'h5, 32'h6}, 1'b0, 1'b0);
        data_valid = 1'b1;
        data = 32'h7;
        rst = 1'b1;
        #1;
        check("t6_rst_en", {mem_cen_n, mem_wen_n, mem_oen_n}, 6'h3f);
        check("t6_rst_ctl", {cmd_ready, data_ready, loading, done, cmd_error}, 5'b0);
        check("t6_rst_data", {mem_addr, mem_din, mismatch_count, first_mismatch_addr}, '0);
        exp_q.delete();
        data_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("t6_ready_after_rst", cmd_ready, 1);
        issue(1'b0, 2'd1, 11'h005, 12'd2);
        stream(1'b0, 2'd1, 11'h005, 2, '{32'hC0, 32'hC1}, 1'b0, 1'b1);
        wait_done(c);
        check("t6_done_latency", c, 3);
        check("t6_queue_empty", exp_q.size(), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
